controller_mc: RTL and testbench
================================

# controller_mc

Multicycle successor to the single-cycle ARM control unit. It sequences each instruction through a Moore state machine, so the datapath can share one memory and one ALU across cycles. It evaluates all 16 ARM condition codes against a flag register it holds internally, and can be built with an optional wider ALU opcode set (EOR, CMP, TST). It sits between the instruction register and the multicycle datapath. It replaces the decoder/condlogic pair in multicycle builds.

## Interface
Parameters:
- `ALUCTRL_W`, default 3: ALUControl width. 2 gives ADD/SUB/AND/ORR only. 3 adds EOR.
- `CMP_EN`, default 1: when 1, CMP and TST decode as flag-only ops. When 0 they are illegal.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `Instr`, in, 32: instruction register contents, stable from DECODE onward.
- `ALUFlags`, in, 4: {N,Z,C,V} from the ALU in the current cycle.
- `PCWrite`, out, 1: PC load enable.
- `AdrSrc`, out, 1: memory address select. 0 = PC, 1 = ALUResult register.
- `MemWrite`, out, 1: data memory write enable.
- `IRWrite`, out, 1: instruction register load enable.
- `ResultSrc`, out, 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`, out, 1: ALU A select. 0 = RD1, 1 = PC.
- `ALUSrcB`, out, 2: ALU B select. 00 = RD2, 01 = ExtImm, 10 = constant 4.
- `ALUControl`, out, ALUCTRL_W: 0 = ADD, 1 = SUB, 2 = AND, 3 = ORR, 4 = EOR.
- `ImmSrc`, out, 2: immediate format. 00 = imm8, 01 = imm12, 10 = imm24.
- `RegSrc`, out, 2: register address mux selects (same meaning as the single-cycle block).
- `RegWrite`, out, 1: register file write enable.
- `Illegal`, out, 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `State`, out, 4: current state encoding, for debug.

## Operation
States:
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALU=ADD, ResultSrc=10. Always → DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALU=ADD (computes PC+8). Evaluates CondEx from the Cond field (Instr[31:28]) and the Flags register, and latches it into CondExR.
  - Illegal opcode → FETCH with `Illegal`=1.
  - Op=01 (memory) → MEMADR.
  - Op=00 with Instr[25]=0 → EXECR.
  - Op=00 with Instr[25]=1 → EXECI.
  - Op=10 (branch) → BRANCH.
- MEMADR: ALUSrcB=01, ALU=ADD (U bit ignored). L=1 → MEMRD, L=0 → MEMWR.
- MEMRD: AdrSrc=1. → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondExR. → FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondExR. → FETCH.
- EXECR / EXECI: ALUSrcB=00 (EXECR) or 01 (EXECI). ALUControl comes from the decoded cmd.
  - Flags update at the clock edge if CondExR and FlagW.
  - Flag-only ops (CMP/TST) → FETCH. Others → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondExR. → FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALU=ADD, ResultSrc=10, PCWrite=CondExR. → FETCH.

Data-processing decode (cmd = Instr[24:21]):
- 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
- 0001 EOR: only when ALUCTRL_W≥3.
- 1010 CMP (runs SUB) and 1000 TST (runs AND): only when CMP_EN. Both write flags regardless of the S bit.
- Any other cmd, or Op=11: illegal.

Flag-write rules (FlagW[1] enables NZ, FlagW[0] enables CV):
- ADD/SUB/CMP with S: FlagW=11.
- AND/ORR/EOR/TST with S: FlagW=10. C and V are preserved.

Rd=15 write-back:
- When Rd=15 in ALUWB or MEMWB, PCWrite=CondExR as well as RegWrite.

Condition codes:
- All 16 ARM codes: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL.
- 1111 is treated as AL.

Default output values:
- Unlisted outputs are 0 in every state.
- `ALUControl` defaults to ADD.

## Timing
- Reset: state=FETCH, Flags=0000, CondExR=0, asynchronous on `reset_n` low.
  - While in reset, outputs show the FETCH values (IRWrite=1, PCWrite=1).
  - Outputs are combinational from state, so a reset asserted mid-instruction aborts it immediately. No partial write completes after reset asserts.
- Instruction latency in cycles: B 3; STR 4; CMP/TST 3; DP 4; LDR 5.
- Flags update only on the EXEC→next clock edge. CondEx for instruction N+1 sees the flags written by instruction N.
- `Instr` is sampled combinationally from DECODE onward. The datapath must hold IR, which is guaranteed because IRWrite=0 outside FETCH.

## Structure
- Shared package `arm_mc_pkg` holds:
  - the `state_t` enum (4-bit);
  - the ALU opcode localparams;
  - the condition-code constants;
  - the `ResultSrc` and `ALUSrcB` encodings.
- One sub-module, `condcheck_mc`: combinational evaluation of Cond and Flags into CondEx. The FSM, decode logic, Flags register and CondExR live in the top module.

## Test plan
- Reset mid-MEMWR (STR, CondEx=1) → MemWrite drops the same cycle; after release the block is in FETCH with Flags=0000.
- `SUBS R1,R1,R1` then `BEQ` → Flags=0100 (Z set) after EXECR; BRANCH asserts PCWrite; B completes in 3 cycles.
- `ADDNE` with Z=1 → ALUWB is entered with RegWrite=0; Flags unchanged.
- `LDR` (Op=01, L=1) → FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 only in MEMWB; ResultSrc=01.
- `ANDS` with a prior C=1, V=1 → NZ updated, C and V still 1; `CMP` with S=0 still writes all four flags and returns to FETCH after EXECR.
- ALUCTRL_W=2 build with cmd=0001 (EOR) → `Illegal` pulses in DECODE, no writes, next state FETCH; the same stimulus with ALUCTRL_W=3 → ALUControl=4.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, ALU opcodes,
// data-processing cmd values, condition codes and datapath mux selects.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/condcheck_mc.sv
// Combinational ARM condition evaluation: Cond field against held {N,Z,C,V}.
module condcheck_mc
    import arm_mc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        condex = 1'b1;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = z | (n != v);
            // NV is deliberately executed unconditionally, like AL
            COND_AL, COND_NV: condex = 1'b1;
        endcase
    end
endmodule

// File: rtl/controller_mc.sv
// Multicycle ARM control unit: Moore FSM over FETCH..BRANCH, internal NZCV
// register, and CondExR gating every architectural write of the instruction.
module controller_mc
    import arm_mc_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit CMP_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          Instr,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic                 RegWrite,
    output logic                 Illegal,
    output logic [3:0]           State
);
    state_t     state, state_n;
    logic [3:0] flags;
    logic       condex, condexr;
    logic [1:0] op, flagw;
    logic [3:0] cmd;
    logic       s_bit, rd_pc, dp_legal, dp_arith, flag_only, illegal_op, in_exec;
    logic [2:0] dp_alu, alu_sel;
    logic       unused_bits;

    assign op          = Instr[27:26];
    assign cmd         = Instr[24:21];
    assign s_bit       = Instr[20];
    assign rd_pc       = (Instr[15:12] == 4'd15);
    assign unused_bits = ^{Instr[19:16], Instr[11:0]};

    condcheck_mc u_condcheck (.cond(Instr[31:28]), .flags(flags), .condex(condex));

    always_comb begin
        dp_legal  = 1'b1;
        dp_arith  = 1'b0;
        flag_only = 1'b0;
        dp_alu    = ALU_ADD;
        case (cmd)
            CMD_ADD: begin dp_alu = ALU_ADD; dp_arith = 1'b1; end
            CMD_SUB: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
            CMD_AND: dp_alu = ALU_AND;
            CMD_ORR: dp_alu = ALU_ORR;
            CMD_EOR: begin dp_alu = ALU_EOR; dp_legal = (ALUCTRL_W >= 3); end
            CMD_CMP: begin dp_alu = ALU_SUB; dp_arith = 1'b1; flag_only = 1'b1; dp_legal = CMP_EN; end
            CMD_TST: begin dp_alu = ALU_AND; flag_only = 1'b1; dp_legal = CMP_EN; end
            default: dp_legal = 1'b0;
        endcase
    end

    assign illegal_op = (op == 2'b11) || ((op == OP_DP) && !dp_legal);
    // CMP/TST always write flags; logical ops leave C and V untouched
    assign flagw      = (s_bit || flag_only) ? (dp_arith ? 2'b11 : 2'b10) : 2'b00;
    assign in_exec    = (state == S_EXECR) || (state == S_EXECI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_FETCH;
            flags   <= 4'b0000;
            condexr <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_DECODE) condexr <= condex;
            if (in_exec && condexr) begin
                if (flagw[1]) flags[3:2] <= ALUFlags[3:2];
                if (flagw[0]) flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        state_n   = state;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        alu_sel   = ALU_ADD;
        RegWrite  = 1'b0;
        Illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_n   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (illegal_op) begin
                    Illegal = 1'b1;
                    state_n = S_FETCH;
                end else if (op == OP_MEM) begin
                    state_n = S_MEMADR;
                end else if (op == OP_BR) begin
                    state_n = S_BRANCH;
                end else begin
                    state_n = Instr[25] ? S_EXECI : S_EXECR;
                end
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_n = Instr[20] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_n = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = condexr;
                PCWrite   = condexr & rd_pc;
                state_n   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = condexr;
                state_n  = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB = (state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                alu_sel = dp_alu;
                state_n = flag_only ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = condexr;
                PCWrite   = condexr & rd_pc;
                state_n   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = condexr;
                state_n   = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

    assign ALUControl = ALUCTRL_W'(alu_sel);
    assign ImmSrc     = ((state != S_FETCH) && (op != 2'b11)) ? op : 2'b00;
    assign RegSrc     = (state != S_FETCH) ? {op == OP_MEM, op == OP_BR} : 2'b00;
    assign State      = state;
endmodule

// File: tb/tb_controller_mc.sv
// Scoreboard bench for controller_mc: per-cycle expected output vectors queued
// by the driver, popped and compared on every falling edge by the monitor.
module tb_controller_mc;
    localparam int W = 22;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw;
        logic [1:0] rs;
        logic       sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic       rw, il;
        logic [3:0] fl;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr = 32'h0, instr2 = 32'h0;
    logic [3:0]  alu_flags = 4'h0;
    always #5 clk = ~clk;

    logic       pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write, illegal;
    logic [1:0] result_src, alu_src_b, imm_src_unused, reg_src_unused;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
    logic       pc_write2, adr_src2, mem_write2, ir_write2, alu_src_a2, reg_write2, illegal2;
    logic [1:0] result_src2, alu_src_b2, imm_src2_unused, reg_src2_unused, alu_ctrl2;
    logic [3:0] state2;

    controller_mc #(.ALUCTRL_W(3), .CMP_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .Instr(instr), .ALUFlags(alu_flags),
        .PCWrite(pc_write), .AdrSrc(adr_src), .MemWrite(mem_write), .IRWrite(ir_write),
        .ResultSrc(result_src), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUControl(alu_ctrl),
        .ImmSrc(imm_src_unused), .RegSrc(reg_src_unused), .RegWrite(reg_write),
        .Illegal(illegal), .State(state));

    controller_mc #(.ALUCTRL_W(2), .CMP_EN(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .Instr(instr2), .ALUFlags(alu_flags),
        .PCWrite(pc_write2), .AdrSrc(adr_src2), .MemWrite(mem_write2), .IRWrite(ir_write2),
        .ResultSrc(result_src2), .ALUSrcA(alu_src_a2), .ALUSrcB(alu_src_b2), .ALUControl(alu_ctrl2),
        .ImmSrc(imm_src2_unused), .RegSrc(reg_src2_unused), .RegWrite(reg_write2),
        .Illegal(illegal2), .State(state2));

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$], exp2_q[$];
    string        tag_q[$], tag2_q[$];
    int           n_vec = 0, n_fail = 0;

    task automatic check(input logic [W-1:0] act, input logic [W-1:0] exp, input string tag);
        vec_t a, e;
        a = act;
        e = exp;
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b (state %0d) want %b (state %0d)", tag, act, a.st, exp, e.st);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0)
            check({state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                   alu_src_b, alu_ctrl, reg_write, illegal, dut.flags},
                  exp_q.pop_front(), tag_q.pop_front());
        if (exp2_q.size() > 0)
            check({state2, pc_write2, adr_src2, mem_write2, ir_write2, result_src2, alu_src_a2,
                   alu_src_b2, 1'b0, alu_ctrl2, reg_write2, illegal2, dut2.flags},
                  exp2_q.pop_front(), tag2_q.pop_front());
    end

    // ---------------- expected vectors (hand-specified per state) ----------------
    function automatic vec_t v(input logic [3:0] st, input logic pcw, adr, mw, irw,
                               input logic [1:0] rs, input logic sa, input logic [1:0] sb,
                               input logic [2:0] alu, input logic rw, il, input logic [3:0] fl);
        return '{st, pcw, adr, mw, irw, rs, sa, sb, alu, rw, il, fl};
    endfunction

    function automatic vec_t vf(input logic [3:0] fl);                    return v(0, 1, 0, 0, 1, 2'b10, 1, 2'b10, 0, 0, 0, fl); endfunction
    function automatic vec_t vd(input logic il, input logic [3:0] fl);    return v(1, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 0, il, fl); endfunction
    function automatic vec_t vmadr(input logic [3:0] fl);                 return v(2, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 0, 0, fl); endfunction
    function automatic vec_t vmrd(input logic [3:0] fl);                  return v(3, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, fl); endfunction
    function automatic vec_t vmwb(input logic rw, pcw, input logic [3:0] fl); return v(4, pcw, 0, 0, 0, 2'b01, 0, 2'b00, 0, rw, 0, fl); endfunction
    function automatic vec_t vmwr(input logic mw, input logic [3:0] fl);  return v(5, 0, 1, mw, 0, 2'b00, 0, 2'b00, 0, 0, 0, fl); endfunction
    function automatic vec_t vex(input logic imm, input logic [2:0] alu, input logic [3:0] fl);
        return v(imm ? 4'd7 : 4'd6, 0, 0, 0, 0, 2'b00, 0, imm ? 2'b01 : 2'b00, alu, 0, 0, fl);
    endfunction
    function automatic vec_t vwb(input logic rw, pcw, input logic [3:0] fl); return v(8, pcw, 0, 0, 0, 2'b00, 0, 2'b00, 0, rw, 0, fl); endfunction
    function automatic vec_t vbr(input logic pcw, input logic [3:0] fl);  return v(9, pcw, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0, fl); endfunction

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] dp(input logic [3:0] cond, input logic i, input logic [3:0] cmd,
                                       input logic s, input logic [3:0] rd);
        return {cond, 2'b00, i, cmd, s, 4'd1, rd, 12'h002};
    endfunction
    function automatic logic [31:0] ldst(input logic [3:0] cond, input logic l, input logic [3:0] rd);
        return {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, l, 4'd2, rd, 12'h004};
    endfunction
    function automatic logic [31:0] br(input logic [3:0] cond);
        return {cond, 2'b10, 2'b10, 24'h000010};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push(input vec_t e, input string t);  exp_q.push_back(e);  tag_q.push_back(t);  endtask
    task automatic push2(input vec_t e, input string t); exp2_q.push_back(e); tag2_q.push_back(t); endtask
    task automatic issue(input logic [31:0] ins, input logic [3:0] af); instr = ins; alu_flags = af; endtask
    task automatic step(input int n); repeat (n) @(posedge clk); #1; endtask

    task automatic branch_sweep(input logic [15:0] taken, input logic [3:0] fl, input string name);
        for (int c = 0; c < 16; c++) begin
            issue(br(4'(c)), 4'hF);
            push(vf(fl), $sformatf("%s_f%0d", name, c));
            push(vd(0, fl), $sformatf("%s_d%0d", name, c));
            push(vbr(taken[c], fl), $sformatf("%s_br%0d", name, c));
            step(3);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic [3:0] rd;
        rd = 4'($urandom_range(0, 14));

        // reset: outputs show FETCH values, flags clear
        issue(dp(4'hE, 0, 4'b0100, 0, rd), 4'h0);
        instr2 = dp(4'hE, 0, 4'b0100, 0, rd);
        repeat (2) @(posedge clk);
        #1;
        push(vf(4'b0000), "reset_fetch");
        push2(vf(4'b0000), "reset_fetch2");
        step(1);
        reset_n = 1'b1;

        // EOR: legal with 3-bit ALUControl, illegal in the 2-bit build; CMP illegal without CMP_EN
        issue(dp(4'hE, 0, 4'b0001, 0, rd), 4'h0);
        instr2 = dp(4'hE, 0, 4'b0001, 0, rd);
        push(vf(4'h0), "eor_f");       push(vd(0, 4'h0), "eor_d");
        push(vex(0, 3'd4, 4'h0), "eor_ex"); push(vwb(1, 0, 4'h0), "eor_wb");
        push2(vf(4'h0), "eor2_f");     push2(vd(1, 4'h0), "eor2_illegal");
        step(2);
        instr2 = dp(4'hE, 0, 4'b1010, 0, 4'd0);
        push2(vf(4'h0), "cmp2_f");     push2(vd(1, 4'h0), "cmp2_illegal");
        step(2);

        // SUBS R1,R1,R1 sets Z, then BEQ taken / BNE not taken
        issue(dp(4'hE, 0, 4'b0010, 1, 4'd1), 4'b0100);
        push(vf(4'h0), "subs_f");  push(vd(0, 4'h0), "subs_d");
        push(vex(0, 3'd1, 4'h0), "subs_ex"); push(vwb(1, 0, 4'b0100), "subs_wb");
        step(4);
        issue(br(4'h0), 4'h0);
        push(vf(4'b0100), "beq_f"); push(vd(0, 4'b0100), "beq_d"); push(vbr(1, 4'b0100), "beq_br");
        step(3);
        issue(br(4'h1), 4'h0);
        push(vf(4'b0100), "bne_f"); push(vd(0, 4'b0100), "bne_d"); push(vbr(0, 4'b0100), "bne_br");
        step(3);

        // ADDNES with Z=1: no register write, flags held despite S
        issue(dp(4'h1, 1, 4'b0100, 1, rd), 4'b1001);
        push(vf(4'b0100), "addne_f"); push(vd(0, 4'b0100), "addne_d");
        push(vex(1, 3'd0, 4'b0100), "addne_ex"); push(vwb(0, 0, 4'b0100), "addne_wb");
        step(4);

        // LDR to a GPR, then LDR to PC
        issue(ldst(4'hE, 1, rd), 4'h0);
        push(vf(4'b0100), "ldr_f"); push(vd(0, 4'b0100), "ldr_d"); push(vmadr(4'b0100), "ldr_adr");
        push(vmrd(4'b0100), "ldr_rd"); push(vmwb(1, 0, 4'b0100), "ldr_wb");
        step(5);
        issue(ldst(4'hE, 1, 4'd15), 4'h0);
        push(vf(4'b0100), "ldrpc_f"); push(vd(0, 4'b0100), "ldrpc_d"); push(vmadr(4'b0100), "ldrpc_adr");
        push(vmrd(4'b0100), "ldrpc_rd"); push(vmwb(1, 1, 4'b0100), "ldrpc_wb");
        step(5);

        // CMP without S writes all four flags and finishes after EXECR
        issue(dp(4'hE, 0, 4'b1010, 0, 4'd0), 4'b0011);
        push(vf(4'b0100), "cmp_f"); push(vd(0, 4'b0100), "cmp_d"); push(vex(0, 3'd1, 4'b0100), "cmp_ex");
        step(3);
        // ANDS updates NZ only; C,V stay 1
        issue(dp(4'hE, 0, 4'b0000, 1, rd), 4'b1000);
        push(vf(4'b0011), "ands_f"); push(vd(0, 4'b0011), "ands_d");
        push(vex(0, 3'd2, 4'b0011), "ands_ex"); push(vwb(1, 0, 4'b1011), "ands_wb");
        step(4);
        branch_sweep(16'hD556, 4'b1011, "cc1011");

        // TST immediate without S writes NZ; ORR without S leaves flags alone
        issue(dp(4'hE, 1, 4'b1000, 0, 4'd0), 4'b0100);
        push(vf(4'b1011), "tst_f"); push(vd(0, 4'b1011), "tst_d"); push(vex(1, 3'd2, 4'b1011), "tst_ex");
        step(3);
        issue(dp(4'hE, 0, 4'b1100, 0, rd), 4'b1111);
        push(vf(4'b0111), "orr_f"); push(vd(0, 4'b0111), "orr_d");
        push(vex(0, 3'd3, 4'b0111), "orr_ex"); push(vwb(1, 0, 4'b0111), "orr_wb");
        step(4);
        branch_sweep(16'hEA65, 4'b0111, "cc0111");

        // STRNE (not executed), STR, then STR aborted by reset inside MEMWR
        issue(ldst(4'h1, 0, rd), 4'h0);
        push(vf(4'b0111), "strne_f"); push(vd(0, 4'b0111), "strne_d");
        push(vmadr(4'b0111), "strne_adr"); push(vmwr(0, 4'b0111), "strne_wr");
        step(4);
        issue(ldst(4'hE, 0, rd), 4'h0);
        push(vf(4'b0111), "str_f"); push(vd(0, 4'b0111), "str_d");
        push(vmadr(4'b0111), "str_adr"); push(vmwr(1, 4'b0111), "str_wr");
        step(4);
        issue(ldst(4'hE, 0, rd), 4'h0);
        push(vf(4'b0111), "strrst_f"); push(vd(0, 4'b0111), "strrst_d");
        push(vmadr(4'b0111), "strrst_adr"); push(vf(4'b0000), "strrst_abort");
        step(3);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        issue(br(4'h0), 4'h0);
        push(vf(4'h0), "post_rst_f"); push(vd(0, 4'h0), "post_rst_d"); push(vbr(0, 4'h0), "post_rst_beq");
        step(3);

        step(2);
        n_vec++;
        if (exp_q.size() != 0 || exp2_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d expectations left, want 0/0", exp_q.size(), exp2_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
